// File: rtl/prince_ctrl_pkg.sv
// Shared control types and helpers for the PRINCE round sequencer.
package prince_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FWD  = 3'd1,
    S_MID  = 3'd2,
    S_BWD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic int latency(
    input int fwd,
    input int bwd,
    input int sbox,
    input int mid
  );
    return fwd * sbox + mid + bwd * sbox;
  endfunction

  localparam int LATENCY = latency(5, 5, 4, 8);

  // True when value is representable in an unsigned field of width bits.
  function automatic bit fits(input int value, input int width);
    if (width < 1 || width > 30) return 1'b0;
    return value < (1 << width);
  endfunction

endpackage

// File: rtl/prince_stage_counter.sv
// Stage counter with runtime terminal value and wrap pulse.
module prince_stage_counter
  import prince_ctrl_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;

  assign o_count = r_cnt;
  assign o_wrap  = i_en & (r_cnt == i_last);

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prince_round_sequencer.sv
// Round/stage sequencer for the pipelined masked PRINCE core.
module prince_round_sequencer
  import prince_ctrl_pkg::*;
#(
  parameter int SBOX_STAGES = 4,
  parameter int FWD_ROUNDS  = 5,
  parameter int BWD_ROUNDS  = 5,
  parameter int MID_STAGES  = 8,
  parameter int RND_W       = 4,
  parameter int STG_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dec,
  input  logic             done_ack,
  output logic             busy,
  output logic             load_sel,
  output logic [RND_W-1:0] round_o,
  output logic [STG_W-1:0] stage_o,
  output logic             round_last,
  output logic             half_sel,
  output logic             end_sel,
  output logic             dec_o,
  output logic             done
);

  localparam int MAX_STG =
    (SBOX_STAGES > MID_STAGES) ? SBOX_STAGES : MID_STAGES;
  localparam bit CNT_OK =
    (SBOX_STAGES >= 1) && (FWD_ROUNDS >= 1) &&
    (BWD_ROUNDS >= 1) && (MID_STAGES >= 1);
  localparam bit WID_OK =
    fits(FWD_ROUNDS + BWD_ROUNDS + 1, RND_W) &&
    fits(MAX_STG - 1, STG_W);

  if (!CNT_OK) begin : g_bad_count
    $error("prince_round_sequencer: count parameter below 1");
  end
  if (!WID_OK) begin : g_bad_width
    $error("prince_round_sequencer: RND_W or STG_W too narrow");
  end

  localparam logic [RND_W-1:0] L_FWD  = RND_W'(FWD_ROUNDS);
  localparam logic [RND_W-1:0] L_LAST =
    RND_W'(FWD_ROUNDS + BWD_ROUNDS + 1);
  localparam logic [STG_W-1:0] L_SBOX = STG_W'(SBOX_STAGES - 1);
  localparam logic [STG_W-1:0] L_MID  = STG_W'(MID_STAGES - 1);

  state_t           r_state;
  logic [RND_W-1:0] r_round;
  logic             r_dec;

  logic             w_run;
  logic             w_wrap;
  logic [STG_W-1:0] w_last;
  logic [STG_W-1:0] w_stage;

  assign w_run  = (r_state == S_FWD) || (r_state == S_MID) ||
                  (r_state == S_BWD);
  assign w_last = (r_state == S_MID) ? L_MID : L_SBOX;

  prince_stage_counter #(
    .W(STG_W)
  ) u_stage (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (load_sel),
    .i_en    (w_run),
    .i_last  (w_last),
    .o_count (w_stage),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_round <= '0;
      r_dec   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FWD;
            r_round <= RND_W'(1);
            r_dec   <= dec;
          end
        end
        S_FWD: begin
          if (w_wrap) begin
            r_round <= r_round + 1'b1;
            if (r_round == L_FWD) r_state <= S_MID;
          end
        end
        S_MID: begin
          if (w_wrap) begin
            r_round <= r_round + 1'b1;
            r_state <= S_BWD;
          end
        end
        S_BWD: begin
          if (w_wrap) begin
            if (r_round == L_LAST) begin
              r_state <= S_DONE;
              r_round <= '0;
            end else begin
              r_round <= r_round + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (done_ack) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_round <= '0;
        end
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign load_sel   = start & (r_state == S_IDLE);
  assign round_o    = r_round;
  assign stage_o    = w_stage;
  assign round_last = w_wrap;
  assign half_sel   = (r_state == S_MID) || (r_state == S_BWD);
  assign end_sel    = (r_state == S_BWD) && (r_round == L_LAST);
  assign dec_o      = r_dec;

endmodule
